// File: rtl/uart_iccm_loader.sv
// Boot-time UART loader: assembles little-endian 32-bit words from 8N1 serial
// frames and writes them into the ICCM while holding the core in reset.
module uart_iccm_loader #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] END_WORD = 32'h0000_0FFF,
    parameter logic [15:0] MIN_CPB  = 16'd4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              prog_i,
    input  logic              rx_i,
    input  logic [15:0]       clks_per_bit_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic              prog_rst_no,
    output logic              frame_err_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {C_OFF, C_LOAD, C_WRITE, C_DONE} ctrl_e;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_e;

    logic [1:0]        rx_sync_q;
    logic              prog_q, prog_d1_q;
    ctrl_e             ctrl_q, ctrl_d;
    rx_e               rx_state_q, rx_state_d;
    logic [15:0]       tick_q, tick_d;
    logic [15:0]       cpb_q, cpb_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              rx_valid_q, rx_valid_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              prog_rst_n_q, prog_rst_n_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;

    logic        rx_s;
    logic        prog_rise_s, prog_fall_s;
    logic        abort_s, frame_fail_s;
    logic [15:0] cpb_in_s;
    logic [31:0] word_full_s;

    assign rx_s        = rx_sync_q[1];
    assign prog_rise_s = prog_q & ~prog_d1_q;
    assign prog_fall_s = ~prog_q & prog_d1_q;
    assign cpb_in_s    = (clks_per_bit_i < MIN_CPB) ? MIN_CPB : clks_per_bit_i;
    assign word_full_s = {shift_q, word_q[23:0]};

    // Control FSM: session sequencing, word assembly and ICCM write port.
    always_comb begin
        ctrl_d      = ctrl_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        frame_err_d = frame_err_q | frame_fail_s;
        abort_s     = 1'b0;
        case (ctrl_q)
            C_OFF: begin
                if (prog_rise_s) begin
                    ctrl_d      = C_LOAD;
                    addr_d      = '0;
                    byte_cnt_d  = 2'd0;
                    frame_err_d = 1'b0;
                end else begin
                    ctrl_d = C_OFF;
                end
            end
            C_LOAD: begin
                if (prog_fall_s) begin
                    ctrl_d     = C_OFF;
                    abort_s    = 1'b1;
                    byte_cnt_d = 2'd0;
                end else if (rx_valid_q) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = shift_q;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        ctrl_d = C_WRITE;
                        // The strobe is registered on entry so it is high exactly during WRITE.
                        if (word_full_s != END_WORD) begin
                            we_d    = 1'b1;
                            wdata_d = word_full_s;
                        end else begin
                            we_d = 1'b0;
                        end
                    end else begin
                        ctrl_d = C_LOAD;
                    end
                end else begin
                    ctrl_d = C_LOAD;
                end
            end
            C_WRITE: begin
                if (we_q) begin
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    addr_d = addr_q;
                end
                if (prog_fall_s) begin
                    ctrl_d     = C_OFF;
                    abort_s    = 1'b1;
                    byte_cnt_d = 2'd0;
                end else if (we_q) begin
                    ctrl_d = C_LOAD;
                end else begin
                    ctrl_d = C_DONE;
                end
            end
            C_DONE: begin
                if (!prog_q) begin
                    ctrl_d = C_OFF;
                end else begin
                    ctrl_d = C_DONE;
                end
            end
            default: ctrl_d = C_OFF;
        endcase
        busy_d       = (ctrl_d == C_LOAD) || (ctrl_d == C_WRITE);
        prog_rst_n_d = ~busy_d;
    end

    // RX FSM: 8N1 receiver, only armed while the control FSM is loading.
    always_comb begin
        rx_state_d   = rx_state_q;
        tick_d       = tick_q + 16'd1;
        cpb_d        = cpb_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        rx_valid_d   = 1'b0;
        frame_fail_s = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                tick_d = 16'd0;
                if ((ctrl_q == C_LOAD) && !rx_s) begin
                    rx_state_d = R_START;
                    cpb_d      = cpb_in_s;
                end else begin
                    rx_state_d = R_IDLE;
                end
            end
            R_START: begin
                if (tick_q == (cpb_q >> 1) - 16'd1) begin
                    tick_d    = 16'd0;
                    bit_idx_d = 3'd0;
                    if (rx_s) begin
                        rx_state_d = R_IDLE;
                    end else begin
                        rx_state_d = R_DATA;
                    end
                end else begin
                    rx_state_d = R_START;
                end
            end
            R_DATA: begin
                if (tick_q == cpb_q - 16'd1) begin
                    tick_d    = 16'd0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end else begin
                        rx_state_d = R_DATA;
                    end
                end else begin
                    rx_state_d = R_DATA;
                end
            end
            R_STOP: begin
                if (tick_q == cpb_q - 16'd1) begin
                    rx_state_d = R_IDLE;
                    if (rx_s) begin
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_fail_s = 1'b1;
                    end
                end else begin
                    rx_state_d = R_STOP;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
        if (abort_s) begin
            rx_state_d = R_IDLE;
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_sync_q    <= 2'b11;
            prog_q       <= 1'b0;
            prog_d1_q    <= 1'b0;
            ctrl_q       <= C_OFF;
            rx_state_q   <= R_IDLE;
            tick_q       <= 16'd0;
            cpb_q        <= MIN_CPB;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            rx_valid_q   <= 1'b0;
            byte_cnt_q   <= 2'd0;
            word_q       <= 32'd0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            we_q         <= 1'b0;
            prog_rst_n_q <= 1'b1;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_sync_q    <= {rx_sync_q[0], rx_i};
            prog_q       <= prog_i;
            prog_d1_q    <= prog_q;
            ctrl_q       <= ctrl_d;
            rx_state_q   <= rx_state_d;
            tick_q       <= tick_d;
            cpb_q        <= cpb_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_valid_q   <= rx_valid_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            prog_rst_n_q <= prog_rst_n_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign prog_rst_no = prog_rst_n_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = busy_q;

endmodule

// File: doc/uart_iccm_loader.md
# uart_iccm_loader

Boot-time UART loader that receives a program image over the serial line and writes it word by word into the instruction memory through the ICCM controller write port (`we_o`/`addr_o`/`wdata_o`). It sits upstream of the instruction-memory adapter and shares `rx_i` with the UART peripheral. While a session is active it holds the core in reset through `prog_rst_no`, and it releases the core when an end word arrives or when `prog_i` drops.

## Interface
Parameters:
- `ADDR_W`, 12: width of the ICCM word address.
- `END_WORD`, 32'h0000_0FFF: terminator word. It is never written to memory.
- `MIN_CPB`, 4: lower clamp applied to `clks_per_bit_i`.

Ports:
- `clk_i`  in  1: system clock. Only clock.
- `rst_i`  in  1: synchronous, active-high reset.
- `prog_i`  in  1: programming-mode request, level.
- `rx_i`  in  1: UART receive line, asynchronous, idles high.
- `clks_per_bit_i`  in  16: clock cycles per UART bit.
- `we_o`  out  1: ICCM write strobe, one-cycle pulse.
- `addr_o`  out  ADDR_W: ICCM word address.
- `wdata_o`  out  32: ICCM write data.
- `prog_rst_no`  out  1: active-low hold for core and memory adapters.
- `frame_err_o`  out  1: sticky stop-bit error flag.
- `busy_o`  out  1: high while in LOAD or WRITE.

## Operation
- **Reset values** (all outputs): `we_o`=0, `addr_o`=0, `wdata_o`=0, `prog_rst_no`=1, `frame_err_o`=0, `busy_o`=0. Control FSM = OFF. RX FSM = IDLE.
- **Input synchronisation**: `rx_i` passes through 2 flops. `prog_i` is registered once and edge-detected. The registered copy resets to 0, so `prog_i` high out of reset counts as a rising edge.
- **Bit period**: `cpb` = max(`clks_per_bit_i`, MIN_CPB). It is latched at each start-bit detect.
- **RX FSM** (states IDLE, START, DATA, STOP):
  - IDLE to START on synced rx = 0, but only when the control FSM is in LOAD. Otherwise rx is ignored.
  - START: after floor(cpb/2) cycles, sample rx. If 1, it was a glitch: return to IDLE. If 0, go to DATA.
  - DATA: sample every cpb cycles, 8 bits, LSB first.
  - STOP: sample after cpb cycles.
    - If 1: the byte is valid.
    - If 0: set `frame_err_o` and discard the byte; the byte count does not advance.
  - STOP returns to IDLE in the cycle after the stop sample, so back-to-back frames are accepted.
- **Word assembly**: byte k (k = 0..3) lands in bits [8k+7:8k]. The byte counter is 2 bits.
- **Control FSM** (states OFF, LOAD, WRITE, DONE):
  - OFF → LOAD on a `prog_i` rising edge. On entry: `addr_o`=0, byte count=0, `frame_err_o`=0, `prog_rst_no`=0.
  - LOAD → WRITE when the 4th valid byte completes the word.
  - WRITE (one cycle):
    - If word ≠ END_WORD: `we_o`=1, `wdata_o`=word, `addr_o` unchanged. `addr_o` increments on the next cycle, modulo 2^ADDR_W (4095 wraps to 0). Return to LOAD.
    - If word = END_WORD: no write. Go to DONE.
  - DONE: `prog_rst_no`=1 and rx is ignored. When `prog_i` goes low, return to OFF. A new rising edge is needed to start another session.
  - `prog_i` falling while in LOAD or WRITE aborts the session:
    - the partial word is discarded and the RX FSM is forced to IDLE;
    - a pending WRITE of a complete non-END word still issues its write;
    - next state is OFF, with `prog_rst_no`=1 from the following cycle.
  - `prog_i` rising while in DONE: ignored.
- `wdata_o` holds its last value between writes. `we_o` is 0 outside WRITE.
- Assertion of `rst_i` mid-session returns every register to its reset value on the next edge. Any in-flight byte is lost.

## Timing
- `prog_i` rising edge at the input → `prog_rst_no` low 2 cycles later (1 cycle register, 1 cycle FSM).
- `rx_i` falling edge → START entry 3 cycles later (2 sync cycles + detect).
- Stop-bit sample of the 4th byte at cycle S:
  - word complete at S+1;
  - `we_o` high at S+2 for exactly 1 cycle;
  - `addr_o` incremented at S+3.
- END_WORD detected in WRITE at S+2 → `prog_rst_no` high at S+3.
- `frame_err_o` rises in the cycle after the failing stop sample. It clears only on OFF → LOAD or on reset.
- `busy_o` is high exactly while the control FSM is in LOAD or WRITE.

## Test plan
- **Single word**: reset; `prog_i`=1; `clks_per_bit_i`=16; send bytes 0x13,0x05,0x00,0x00. Expect one `we_o` pulse with `addr_o`=0, `wdata_o`=32'h0000_0513; `addr_o`=1 afterwards; `prog_rst_no`=0 throughout.
- **Burst and terminator**: send 3 words 0x11111111, 0x22222222, 0x33333333, then 0x00000FFF. Expect 3 writes at addresses 0, 1, 2, no 4th write, and `prog_rst_no`=1 exactly 1 cycle after the END_WORD WRITE cycle.
- **Frame error**: send byte 0xAA with stop bit 0, then 4 good bytes 0x01..0x04. Expect `frame_err_o`=1 and a single write of 32'h0403_0201 at address 0.
- **Glitch reject**: pulse `rx_i` low for 5 cycles with `clks_per_bit_i`=16. Expect RX to return to IDLE with no byte counted; a following valid word writes normally.
- **Abort and wrap**: preload `addr_o` to 4095 via 4095 writes (or force); send 1 word. Expect the write at 4095, then `addr_o`=0. Then send 2 bytes, drop `prog_i`. Expect no write, `prog_rst_no`=1 the next cycle, state OFF.
- **Reset mid-frame**: assert `rst_i` during DATA. Expect all outputs at reset values the next cycle. With `prog_i` still high, LOAD is re-entered afterwards.
